// File: rtl/gbar_sync_unit.sv
// gbar_sync_unit: global barrier synchronisation across NUM_SOCKETS sockets
// for NUM_BARRIERS independent slots, with optional hierarchical forwarding.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_ready    socket arrival handshake
//   req_id                 barrier slot of the arrival
//   req_size_m1            participating sockets minus one
//   req_socket_id          arriving socket
//   rsp_valid/rsp_id       one-cycle release broadcast
//   up_req_valid/ready/id  forward of a locally complete barrier to the parent
//   up_rsp_valid/id        parent release pulse
//   err                    sticky protocol error
//   busy                   any slot active or a release pending
module gbar_sync_unit #(
    parameter int NUM_SOCKETS  = 4,
    parameter int NUM_BARRIERS = 8,
    parameter int HIERARCHICAL = 0,
    parameter int ID_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    parameter int SK_W = (NUM_SOCKETS > 1) ? $clog2(NUM_SOCKETS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [ID_W-1:0] req_id,
    input  logic [SK_W-1:0] req_size_m1,
    input  logic [SK_W-1:0] req_socket_id,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [ID_W-1:0] rsp_id,
    output logic            up_req_valid,
    output logic [ID_W-1:0] up_req_id,
    input  logic            up_req_ready,
    input  logic            up_rsp_valid,
    input  logic [ID_W-1:0] up_rsp_id,
    output logic            err,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_UP_REQ,
        S_UP_WAIT
    } slot_state_e;

    slot_state_e            state_q [NUM_BARRIERS];
    slot_state_e            state_d [NUM_BARRIERS];
    logic [NUM_SOCKETS-1:0] mask_q  [NUM_BARRIERS];
    logic [NUM_SOCKETS-1:0] mask_d  [NUM_BARRIERS];
    logic [SK_W-1:0]        size_q  [NUM_BARRIERS];
    logic [SK_W-1:0]        size_d  [NUM_BARRIERS];

    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic            up_req_valid_q, up_req_valid_d;
    logic [ID_W-1:0] up_req_id_q, up_req_id_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic                   sock_ok;
    logic [NUM_SOCKETS-1:0] sock_bit;
    logic [NUM_SOCKETS-1:0] cur_mask;
    logic [NUM_SOCKETS-1:0] new_mask;
    logic [SK_W-1:0]        size_sel;
    logic                   take;

    function automatic logic [SK_W:0] popcnt(input logic [NUM_SOCKETS-1:0] m);
        logic [SK_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_SOCKETS; i++) begin
            c = c + (SK_W+1)'(m[i]);
        end
        return c;
    endfunction

    assign req_ready = (state_q[req_id] == S_IDLE) ||
                       (state_q[req_id] == S_COLLECT);

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        size_d         = size_q;
        rsp_valid_d    = 1'b0;
        rsp_id_d       = rsp_id_q;
        up_req_valid_d = up_req_valid_q;
        up_req_id_d    = up_req_id_q;
        err_d          = err_q;
        busy_d         = 1'b0;

        sock_ok  = int'(req_socket_id) < NUM_SOCKETS;
        sock_bit = '0;
        if (sock_ok) begin
            sock_bit[req_socket_id] = 1'b1;
        end
        cur_mask = mask_q[req_id];
        new_mask = cur_mask | sock_bit;
        // A fresh slot takes its size from this arrival; later ones keep it.
        size_sel = (state_q[req_id] == S_IDLE) ? req_size_m1 : size_q[req_id];

        if (req_valid && req_ready) begin
            if (!sock_ok || (cur_mask & sock_bit) != '0) begin
                err_d = 1'b1;
            end else begin
                if (state_q[req_id] == S_COLLECT &&
                    req_size_m1 != size_q[req_id]) begin
                    err_d = 1'b1;
                end
                size_d[req_id] = size_sel;
                // count > size_m1 is count >= size_m1 + 1
                if (popcnt(new_mask) > {1'b0, size_sel}) begin
                    mask_d[req_id] = '0;
                    if (HIERARCHICAL != 0) begin
                        state_d[req_id] = S_UP_REQ;
                    end else begin
                        state_d[req_id] = S_IDLE;
                        rsp_valid_d     = 1'b1;
                        rsp_id_d        = req_id;
                    end
                end else begin
                    mask_d[req_id]  = new_mask;
                    state_d[req_id] = S_COLLECT;
                end
            end
        end

        take = up_req_valid_q && up_req_ready;
        if (take) begin
            state_d[up_req_id_q] = S_UP_WAIT;
        end

        if (up_rsp_valid) begin
            if (HIERARCHICAL != 0 && state_q[up_rsp_id] == S_UP_WAIT) begin
                state_d[up_rsp_id] = S_IDLE;
                rsp_valid_d        = 1'b1;
                rsp_id_d           = up_rsp_id;
            end else begin
                err_d = 1'b1;
            end
        end

        // Re-arbitrate only when no forward is held, so it stays stable.
        if (HIERARCHICAL != 0 && (!up_req_valid_q || take)) begin
            up_req_valid_d = 1'b0;
            for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
                if (state_d[i] == S_UP_REQ) begin
                    up_req_valid_d = 1'b1;
                    up_req_id_d    = ID_W'(i);
                end
            end
        end

        busy_d = rsp_valid_d;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            if (state_d[i] != S_IDLE) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                state_q[i] <= S_IDLE;
                mask_q[i]  <= '0;
                size_q[i]  <= '0;
            end
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            up_req_valid_q <= 1'b0;
            up_req_id_q    <= '0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            size_q         <= size_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            up_req_valid_q <= up_req_valid_d;
            up_req_id_q    <= up_req_id_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign up_req_valid = up_req_valid_q;
    assign up_req_id    = up_req_id_q;
    assign err          = err_q;
    assign busy         = busy_q;

endmodule
